// File: rtl/tpu_host_seq.sv
// tpu_host_seq: sequences one complete matrix job onto the TPU memory-mapped slave port.
// Latency: each A/B write hits the bus one cycle after its input handshake; a C readback word
//   is valid two cycles after its read address, which follows the start write by WAIT_CYC+1.
// Backpressure: in_ready is low whenever the block owns the bus; out_valid is held, with the
//   bus idle, until out_ready.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start / busy / done   job request (ignored while busy), job in progress, end-of-job pulse
//   in_data/valid/ready   operand stream: DIM A rows, DIM B rows, then C rows as lo/hi halves
//   out_data/valid/ready  C half-row readback stream, k = 0 .. 2*DIM-1
//   tpu_addr/r_w/wdata    registered slave bus (all zero when idle); tpu_rdata slave read data
//
// Build option TPU_HOST_ZERO_C_EN: the stream carries only A and B rows; the block writes all
// 2*DIM C half-rows back-to-back with zero data.
module tpu_host_seq #(
  parameter int DIM      = 8,
  parameter int DATAW    = 64,
  parameter int ADDRW    = 16,
  parameter int WAIT_CYC = 3*DIM
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic [DATAW-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [DATAW-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ADDRW-1:0] tpu_addr,
  output logic             tpu_r_w,
  output logic [DATAW-1:0] tpu_wdata,
  input  logic [DATAW-1:0] tpu_rdata
);

  localparam int CW = (DIM > 1) ? $clog2(2*DIM) : 1;
  localparam int WW = $clog2(WAIT_CYC + 1);

  localparam logic [ADDRW-1:0] BASE_A  = ADDRW'(16'h0100);
  localparam logic [ADDRW-1:0] BASE_B  = ADDRW'(16'h0200);
  localparam logic [ADDRW-1:0] BASE_C  = ADDRW'(16'h0300);
  localparam logic [ADDRW-1:0] ADDR_GO = ADDRW'(16'h0400);

  localparam logic [CW-1:0] LAST_ROW  = CW'(DIM - 1);
  localparam logic [CW-1:0] LAST_HALF = CW'(2*DIM - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYC);

  typedef enum logic [3:0] {
    IDLE, LOAD_A, LOAD_B, C_LO, C_HI, C_WR, GO, WAIT, RD_ADDR, RD_CAP, OUT, FIN
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt, cnt_inc;
  logic [WW-1:0]    wait_cnt, wait_nxt;
  logic [ADDRW-1:0] addr_nxt;
  logic             r_w_nxt;
  logic [DATAW-1:0] wdata_nxt;
  logic             cap;

`ifndef TPU_HOST_ZERO_C_EN
  logic [DATAW-1:0] c_lo_buf, c_lo_nxt;
  logic [DATAW-1:0] c_hi_buf, c_hi_nxt;
`endif

  assign cnt_inc   = cnt + 1'b1;
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign out_valid = (state == OUT);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wait_nxt  = wait_cnt;
    addr_nxt  = '0;
    r_w_nxt   = 1'b0;
    wdata_nxt = '0;
    in_ready  = 1'b0;
    cap       = 1'b0;
`ifndef TPU_HOST_ZERO_C_EN
    c_lo_nxt  = c_lo_buf;
    c_hi_nxt  = c_hi_buf;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD_A;
          cnt_nxt   = '0;
        end
      end
      LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid) begin
          addr_nxt  = BASE_A + (ADDRW'(cnt) << 3);
          r_w_nxt   = 1'b1;
          wdata_nxt = in_data;
          if (cnt == LAST_ROW) begin
            cnt_nxt   = '0;
            state_nxt = LOAD_B;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          addr_nxt  = BASE_B + (ADDRW'(cnt) << 3);
          r_w_nxt   = 1'b1;
          wdata_nxt = in_data;
          if (cnt == LAST_ROW) begin
            cnt_nxt = '0;
`ifdef TPU_HOST_ZERO_C_EN
            state_nxt = C_WR;
`else
            state_nxt = C_LO;
`endif
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
`ifndef TPU_HOST_ZERO_C_EN
      C_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          c_lo_nxt  = in_data;
          state_nxt = C_HI;
        end
      end
      C_HI: begin
        // The low-half write is launched here so that it lands on the bus in C_WR and the
        // high half follows on the very next cycle, keeping the pair adjacent.
        in_ready = 1'b1;
        if (in_valid) begin
          c_hi_nxt  = in_data;
          addr_nxt  = BASE_C + (ADDRW'(cnt) << 4);
          r_w_nxt   = 1'b1;
          wdata_nxt = c_lo_buf;
          state_nxt = C_WR;
        end
      end
      C_WR: begin
        addr_nxt  = BASE_C + (ADDRW'(cnt) << 4) + ADDRW'(8);
        r_w_nxt   = 1'b1;
        wdata_nxt = c_hi_buf;
        if (cnt == LAST_ROW) begin
          cnt_nxt   = '0;
          state_nxt = GO;
        end else begin
          cnt_nxt   = cnt_inc;
          state_nxt = C_LO;
        end
      end
`else
      C_WR: begin
        // Zero-fill: one half-row per cycle, lo/hi order falls out of the 8-byte stride.
        addr_nxt = BASE_C + (ADDRW'(cnt) << 3);
        r_w_nxt  = 1'b1;
        if (cnt == LAST_HALF) begin
          cnt_nxt   = '0;
          state_nxt = GO;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
`endif
      GO: begin
        addr_nxt  = ADDR_GO;
        r_w_nxt   = 1'b1;
        wait_nxt  = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        // One extra WAIT cycle launches the first read address, so the bus shows exactly
        // WAIT_CYC idle cycles between the start write and that address.
        if (wait_cnt == WAIT_LAST) begin
          addr_nxt  = BASE_C + (ADDRW'(cnt) << 3);
          state_nxt = RD_ADDR;
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end
      RD_ADDR: begin
        addr_nxt  = BASE_C + (ADDRW'(cnt) << 3);
        state_nxt = RD_CAP;
      end
      RD_CAP: begin
        cap       = 1'b1;
        state_nxt = OUT;
      end
      OUT: begin
        if (out_ready) begin
          if (cnt == LAST_HALF) begin
            cnt_nxt   = '0;
            state_nxt = FIN;
          end else begin
            cnt_nxt   = cnt_inc;
            addr_nxt  = BASE_C + (ADDRW'(cnt_inc) << 3);
            state_nxt = RD_ADDR;
          end
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      wait_cnt  <= '0;
      tpu_addr  <= '0;
      tpu_r_w   <= 1'b0;
      tpu_wdata <= '0;
      out_data  <= '0;
`ifndef TPU_HOST_ZERO_C_EN
      c_lo_buf  <= '0;
      c_hi_buf  <= '0;
`endif
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      wait_cnt  <= wait_nxt;
      tpu_addr  <= addr_nxt;
      tpu_r_w   <= r_w_nxt;
      tpu_wdata <= wdata_nxt;
      if (cap) begin
        out_data <= tpu_rdata;
      end
`ifndef TPU_HOST_ZERO_C_EN
      c_lo_buf  <= c_lo_nxt;
      c_hi_buf  <= c_hi_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_tpu_host_seq.sv
// tb_tpu_host_seq: drives tpu_host_seq through whole matrix jobs against a TPU slave model.
// The reference derives the bus transaction list, its timing and the C = C + A*B readback
// directly from the operand arrays; start, reset and backpressure are exercised on top.
module tb_tpu_host_seq;

  localparam int DIM      = 8;
  localparam int DATAW    = 64;
  localparam int ADDRW    = 16;
  localparam int WAIT_CYC = 3*DIM;
`ifdef TPU_HOST_ZERO_C_EN
  localparam bit ZERO_C = 1'b1;
`else
  localparam bit ZERO_C = 1'b0;
`endif
  localparam int NWORDS = ZERO_C ? 2*DIM : 4*DIM;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             busy, done;
  logic [DATAW-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DATAW-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ADDRW-1:0] tpu_addr;
  logic             tpu_r_w;
  logic [DATAW-1:0] tpu_wdata;
  logic [DATAW-1:0] tpu_rdata = '0;

  tpu_host_seq #(.DIM(DIM), .DATAW(DATAW), .ADDRW(ADDRW), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .tpu_addr(tpu_addr), .tpu_r_w(tpu_r_w), .tpu_wdata(tpu_wdata), .tpu_rdata(tpu_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [95:0] pk(input logic [15:0] a, input logic rw, input logic [63:0] d);
    return {15'b0, a, rw, d};
  endfunction

  // ---------------- TPU slave model ----------------
  logic [63:0] s_a [DIM];
  logic [63:0] s_b [DIM];
  logic [63:0] s_c [2*DIM];

  always @(posedge clk) begin : slave
    int a;
    int ix;
    logic [15:0] acc;
    a = int'(tpu_addr);
    if (tpu_r_w) begin
      if (a >= 'h100 && a < 'h100 + 8*DIM) s_a[(a - 'h100) / 8] = tpu_wdata;
      else if (a >= 'h200 && a < 'h200 + 8*DIM) s_b[(a - 'h200) / 8] = tpu_wdata;
      else if (a >= 'h300 && a < 'h300 + 16*DIM) s_c[(a - 'h300) / 8] = tpu_wdata;
      else if (a == 'h400) begin
        for (int r = 0; r < DIM; r++) begin
          for (int j = 0; j < DIM; j++) begin
            acc = s_c[2*r + j/4][16*(j%4) +: 16];
            for (int k = 0; k < DIM; k++)
              acc = acc + 16'(s_a[r][8*k +: 8]) * 16'(s_b[k][8*j +: 8]);
            s_c[2*r + j/4][16*(j%4) +: 16] = acc;
          end
        end
      end
    end
    if (!tpu_r_w && a >= 'h300 && a < 'h300 + 16*DIM) begin
      ix = (a - 'h300) / 8;
      tpu_rdata <= s_c[ix];
    end else begin
      tpu_rdata <= '0;
    end
  end

  // ---------------- monitors ----------------
  logic [95:0] bus_q[$];
  int          bus_cyc[$];

  always @(negedge clk) begin
    if (rst_n && (tpu_addr != '0 || tpu_r_w || tpu_wdata != '0)) begin
      bus_q.push_back(pk(tpu_addr, tpu_r_w, tpu_wdata));
      bus_cyc.push_back(cyc);
    end
    if (done) done_cnt++;
  end

  // ---------------- stimulus state ----------------
  logic [63:0] av [DIM];
  logic [63:0] bv [DIM];
  logic [63:0] cw [2*DIM];
  logic [63:0] words[$];
  logic [63:0] exp_out [2*DIM];
  logic [95:0] exp_bus[$];
  int          hs_in [NWORDS];
  int          hs_out [2*DIM];

  task automatic chk_reset(input string p);
    chk({p, "_busy"},      96'(busy), 96'(0));
    chk({p, "_done"},      96'(done), 96'(0));
    chk({p, "_in_ready"},  96'(in_ready), 96'(0));
    chk({p, "_out_valid"}, 96'(out_valid), 96'(0));
    chk({p, "_out_data"},  96'(out_data), 96'(0));
    chk({p, "_tpu_addr"},  96'(tpu_addr), 96'(0));
    chk({p, "_tpu_r_w"},   96'(tpu_r_w), 96'(0));
    chk({p, "_tpu_wdata"}, 96'(tpu_wdata), 96'(0));
  endtask

  task automatic drive_in(input bit rnd);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < NWORDS && guard < 4000) begin
      @(negedge clk);
      guard++;
      in_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = words[i];
      if (in_valid && in_ready) begin
        hs_in[i] = cyc;
        i++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    if (i < NWORDS) chk("in_timeout", 96'(i), 96'(NWORDS));
  endtask

  task automatic consume(input bit rnd, input bit bp3);
    int k;
    int guard;
    int hold;
    logic [63:0] held;
    k = 0;
    guard = 0;
    hold = 0;
    held = '0;
    while (k < 2*DIM && guard < 8000) begin
      @(negedge clk);
      guard++;
      if (bp3 && k == 3 && out_valid && hold < 5) begin
        out_ready = 1'b0;
        if (hold == 0) held = out_data;
        else begin
          chk("bp_data_stable", 96'(out_data), 96'(held));
          chk("bp_bus_idle", 96'(tpu_addr), 96'(0));
        end
        hold++;
        continue;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        chk($sformatf("out_k%0d", k), 96'(out_data), 96'(exp_out[k]));
        hs_out[k] = cyc;
        k++;
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    if (k < 2*DIM) chk("out_timeout", 96'(k), 96'(2*DIM));
  endtask

  task automatic poke_start();
    int guard;
    guard = 0;
    while (tpu_addr != 16'h0400 && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!done && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    if (!done) chk("poke_done_timeout", 96'(done), 96'(1));
    start = 1'b1;  // coincident with the done pulse
    @(negedge clk);
    start = 1'b0;
    chk("start_at_done_ignored", 96'(busy), 96'(0));
  endtask

  task automatic run_job(input string name, input bit ident, input bit rnd_in,
                         input bit rnd_out, input bit bp3, input bit poke);
    int terr;
    int s;
    int f;
    for (int r = 0; r < DIM; r++) begin
      av[r] = ident ? (64'h1 << (8*r)) : {$urandom, $urandom};
      bv[r] = {$urandom, $urandom};
    end
    for (int k = 0; k < 2*DIM; k++) cw[k] = (ident || ZERO_C) ? 64'h0 : {$urandom, $urandom};

    words.delete();
    exp_bus.delete();
    for (int r = 0; r < DIM; r++) words.push_back(av[r]);
    for (int r = 0; r < DIM; r++) words.push_back(bv[r]);
    if (!ZERO_C) for (int k = 0; k < 2*DIM; k++) words.push_back(cw[k]);

    for (int r = 0; r < DIM; r++) exp_bus.push_back(pk(16'(16'h0100 + 8*r), 1'b1, av[r]));
    for (int r = 0; r < DIM; r++) exp_bus.push_back(pk(16'(16'h0200 + 8*r), 1'b1, bv[r]));
    for (int k = 0; k < 2*DIM; k++) exp_bus.push_back(pk(16'(16'h0300 + 8*k), 1'b1, cw[k]));
    exp_bus.push_back(pk(16'h0400, 1'b1, 64'h0));
    for (int k = 0; k < 2*DIM; k++) begin
      exp_bus.push_back(pk(16'(16'h0300 + 8*k), 1'b0, 64'h0));
      exp_bus.push_back(pk(16'(16'h0300 + 8*k), 1'b0, 64'h0));
    end

    for (int r = 0; r < DIM; r++) begin
      for (int h = 0; h < 2; h++) begin
        logic [63:0] w;
        w = '0;
        for (int e = 0; e < 4; e++) begin
          int j;
          int sum;
          j = 4*h + e;
          sum = int'(cw[2*r + h][16*e +: 16]);
          for (int k = 0; k < DIM; k++) sum += int'(av[r][8*k +: 8]) * int'(bv[k][8*j +: 8]);
          w[16*e +: 16] = 16'(sum);
        end
        exp_out[2*r + h] = w;
      end
    end

    bus_q.delete();
    bus_cyc.delete();
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, "_busy_after_start"}, 96'(busy), 96'(1));

    fork
      drive_in(rnd_in);
      consume(rnd_out, bp3);
      if (poke) poke_start();
    join
    repeat (3) @(negedge clk);

    chk({name, "_done_cnt"}, 96'(done_cnt), 96'(1));
    chk({name, "_busy_end"}, 96'(busy), 96'(0));
    chk({name, "_bus_len"}, 96'(bus_q.size()), 96'(exp_bus.size()));
    for (int i = 0; i < exp_bus.size() && i < bus_q.size(); i++)
      chk($sformatf("%s_bus%0d", name, i), bus_q[i], exp_bus[i]);

    if (bus_q.size() == exp_bus.size()) begin
      terr = 0;
      for (int i = 0; i < 2*DIM; i++) if (bus_cyc[i] != hs_in[i] + 1) terr++;
      if (ZERO_C) begin
        for (int k = 0; k < 2*DIM; k++) if (bus_cyc[2*DIM + k] != bus_cyc[2*DIM - 1] + 1 + k) terr++;
      end else begin
        for (int r = 0; r < DIM; r++) begin
          if (bus_cyc[2*DIM + 2*r]     != hs_in[2*DIM + 2*r + 1] + 1) terr++;
          if (bus_cyc[2*DIM + 2*r + 1] != hs_in[2*DIM + 2*r + 1] + 2) terr++;
          if (!rnd_in && r < DIM - 1 && hs_in[2*DIM + 2*r + 2] != hs_in[2*DIM + 2*r + 1] + 2) terr++;
        end
      end
      chk({name, "_write_timing"}, 96'(terr), 96'(0));

      s = 4*DIM;
      chk({name, "_start_after_c"}, 96'(bus_cyc[s] - bus_cyc[s - 1]), 96'(1));
      chk({name, "_wait_idle"}, 96'(bus_cyc[s + 1] - bus_cyc[s] - 1), 96'(WAIT_CYC));

      terr = 0;
      for (int k = 0; k < 2*DIM; k++) begin
        f = bus_cyc[s + 1 + 2*k];
        if (bus_cyc[s + 2 + 2*k] != f + 1) terr++;
        if (k > 0 && f != hs_out[k - 1] + 1) terr++;
        if (!rnd_out && !(bp3 && k == 3)) begin
          if (hs_out[k] != f + 2) terr++;
        end else if (hs_out[k] < f + 2) terr++;
      end
      chk({name, "_read_timing"}, 96'(terr), 96'(0));
    end
  endtask

  initial begin
    #12;
    chk_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_in_ready", 96'(in_ready), 96'(0));

    run_job("ident", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a job, away from any clock edge.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset("midrst");
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_idle_busy", 96'(busy), 96'(0));

    run_job("bp", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    run_job("rnd", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
